// File: rtl/sat_narrow_scheduler.sv
// ---------------------------------------------------------------------------
// sat_narrow_scheduler
//
// N requester channels share one registered saturating-narrowing stage.
// A round-robin arbiter picks one valid channel per cycle whenever the
// output register is free. The chosen IW-bit signed sample is clipped to
// OW bits, and the result is tagged with its source channel and the
// direction of any clipping. Per-channel sticky overflow flags and a
// global saturating event counter are kept for controller diagnostics.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   [N]     per-channel request valid
//   in_data    [N*IW]  channel k sample at bits [k*IW +: IW]
//   in_ready   [N]     accept strobe, one-hot or zero, to the granted channel
//   out_valid          output sample valid
//   out_ready          downstream accept
//   out_data   [OW]    saturated sample
//   out_chan   [CW]    source channel of out_data
//   out_sat    [2]     bit1 = clipped to MAX, bit0 = clipped to MIN
//   clr_stats          clears sat_flags and sat_count
//   sat_flags  [N]     sticky "saturated since last clear", one per channel
//   sat_count  [CNTW]  total saturation events, holds at all-ones
// ---------------------------------------------------------------------------
module sat_narrow_scheduler #(
   parameter int N    = 4,
   parameter int IW   = 22,
   parameter int OW   = 16,
   parameter int CW   = 2,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    in_valid,
   input  logic [N*IW-1:0] in_data,
   output logic [N-1:0]    in_ready,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [OW-1:0]   out_data,
   output logic [CW-1:0]   out_chan,
   output logic [1:0]      out_sat,
   input  logic            clr_stats,
   output logic [N-1:0]    sat_flags,
   output logic [CNTW-1:0] sat_count
);

   localparam logic [OW-1:0] MAX_VAL   = {1'b0, {(OW-1){1'b1}}};
   localparam logic [OW-1:0] MIN_VAL   = {1'b1, {(OW-1){1'b0}}};
   localparam logic [CW-1:0] LAST_CHAN = CW'(N-1);

   logic [CW-1:0]    ptr;
   logic [CW-1:0]    grant;
   logic             found;
   logic             can_load;
   logic             xfer;
   logic [N-1:0]     grant_onehot;
   logic [IW-1:0]    sel_data;
   logic [IW-OW-1:0] top;
   logic             pos_ovf;
   logic             neg_ovf;
   logic             sat_event;
   logic [OW-1:0]    sat_data;
   logic [1:0]       sat_code;

   // The output register can take a new sample when it is empty or when
   // its current sample leaves this cycle.
   assign can_load = !out_valid || out_ready;

   // Round-robin search: start one past the last granted channel and wrap,
   // so the most recent winner has the lowest priority next time.
   always_comb begin
      int idx;
      idx   = 0;
      found = 1'b0;
      grant = '0;
      for (int i = 1; i <= N; i++) begin
         idx = (int'(ptr) + i) % N;
         if (!found && in_valid[idx]) begin
            found = 1'b1;
            grant = CW'(idx);
         end
      end
   end

   // The accept strobe only goes out when the stage can actually take the
   // sample, so a channel never sees in_ready while the output is stalled.
   always_comb begin
      grant_onehot = found ? (N'(1) << grant) : '0;
      in_ready     = can_load ? grant_onehot : '0;
      xfer         = can_load && found;
   end

   // Narrowing check: the bits between the sign and the kept field must all
   // equal the sign, otherwise the value does not fit in OW bits.
   always_comb begin
      sel_data = in_data[grant*IW +: IW];
      top      = sel_data[IW-2:OW-1];
      pos_ovf  = !sel_data[IW-1] && (|top);
      neg_ovf  = sel_data[IW-1] && !(&top);
      sat_data = sel_data[OW-1:0];
      sat_code = 2'b00;
      if (pos_ovf) begin
         sat_data = MAX_VAL;
         sat_code = 2'b10;
      end else if (neg_ovf) begin
         sat_data = MIN_VAL;
         sat_code = 2'b01;
      end
      sat_event = xfer && (pos_ovf || neg_ovf);
   end

   // Output register and arbitration pointer. A held sample stays put and
   // the pointer only moves on an actual transfer; reset drops any held
   // sample and gives channel 0 first priority.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
         out_sat   <= 2'b00;
         ptr       <= LAST_CHAN;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= sat_data;
         out_chan  <= grant;
         out_sat   <= sat_code;
         ptr       <= grant;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Statistics are booked when the sample is accepted, not when it leaves.
   // A clear that coincides with an event keeps that event: the flag stays
   // set and the counter restarts at one.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sat_flags <= '0;
         sat_count <= '0;
      end else if (clr_stats) begin
         sat_flags <= sat_event ? grant_onehot : '0;
         sat_count <= sat_event ? CNTW'(1) : '0;
      end else if (sat_event) begin
         sat_flags <= sat_flags | grant_onehot;
         if (sat_count != {CNTW{1'b1}}) begin
            sat_count <= sat_count + CNTW'(1);
         end
      end
   end

endmodule

// File: tb/tb_sat_narrow_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sat_narrow_scheduler
//
// Self-checking bench for sat_narrow_scheduler. A reference model tracks the
// arbitration pointer, output occupancy and statistics; expected output
// samples go into a scoreboard queue at accept time and are compared while
// the DUT presents them. Boundary values come from a constant table, and
// hand-written sequences cover fairness, backpressure, clear/event overlap,
// counter saturation and reset during a held sample.
// ---------------------------------------------------------------------------
module tb_sat_narrow_scheduler;

   localparam int N    = 4;
   localparam int IW   = 22;
   localparam int OW   = 16;
   localparam int CW   = 2;
   localparam int CNTW = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    in_valid;
   logic [N*IW-1:0] in_data;
   logic [N-1:0]    in_ready;
   logic            out_valid;
   logic            out_ready;
   logic [OW-1:0]   out_data;
   logic [CW-1:0]   out_chan;
   logic [1:0]      out_sat;
   logic            clr_stats;
   logic [N-1:0]    sat_flags;
   logic [CNTW-1:0] sat_count;

   typedef struct {
      logic [OW-1:0] data;
      logic [CW-1:0] chan;
      logic [1:0]    sat;
   } exp_t;

   typedef struct {
      int            chan;
      logic [IW-1:0] data;
      logic [OW-1:0] exp_data;
      logic [1:0]    exp_sat;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[4];

   int   checks   = 0;
   int   failures = 0;

   bit   m_valid  = 1'b0;
   int   m_ptr    = N - 1;
   int   m_flags  = 0;
   int   m_count  = 0;

   sat_narrow_scheduler #(
      .N(N), .IW(IW), .OW(OW), .CW(CW), .CNTW(CNTW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_chan  (out_chan),
      .out_sat   (out_sat),
      .clr_stats (clr_stats),
      .sat_flags (sat_flags),
      .sat_count (sat_count)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Reference narrowing done by value range rather than by bit fields.
   function automatic exp_t satModel(input logic [IW-1:0] raw, input int ch);
      exp_t   r;
      longint v;
      longint maxv;
      longint minv;
      v    = longint'($signed(raw));
      maxv = (longint'(1) <<< (OW - 1)) - 1;
      minv = -(longint'(1) <<< (OW - 1));
      r.chan = CW'(ch);
      if (v > maxv) begin
         r.data = OW'(maxv);
         r.sat  = 2'b10;
      end else if (v < minv) begin
         r.data = OW'(minv);
         r.sat  = 2'b01;
      end else begin
         r.data = OW'(v);
         r.sat  = 2'b00;
      end
      return r;
   endfunction

   // One clock cycle: at the falling edge compare the DUT against the model,
   // then advance the model to what the coming rising edge should produce.
   task automatic runCycle();
      bit            can;
      int            g;
      int            idx;
      logic [N-1:0]  exp_rdy;
      exp_t          e;
      bit            ev;
      @(negedge clk);
      checkOutput("sat_flags", 32'(sat_flags), 32'(m_flags));
      checkOutput("sat_count", 32'(sat_count), 32'(m_count));
      can = !m_valid || out_ready;
      g   = -1;
      for (int i = 1; i <= N; i++) begin
         idx = (m_ptr + i) % N;
         if (g < 0 && in_valid[idx]) g = idx;
      end
      exp_rdy = (can && g >= 0) ? N'(1 << g) : '0;
      checkOutput("in_ready", 32'(in_ready), 32'(exp_rdy));
      if (m_valid) begin
         checkOutput("out_valid", 32'(out_valid), 32'd1);
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard_empty actual=0 required=1");
         end else begin
            checkOutput("out_data", 32'(out_data), 32'(sb[0].data));
            checkOutput("out_chan", 32'(out_chan), 32'(sb[0].chan));
            checkOutput("out_sat", 32'(out_sat), 32'(sb[0].sat));
         end
      end else begin
         checkOutput("out_valid", 32'(out_valid), 32'd0);
      end
      if (!rst_n) begin
         m_valid = 1'b0;
         sb.delete();
         m_ptr   = N - 1;
         m_flags = 0;
         m_count = 0;
      end else begin
         if (m_valid && out_ready) begin
            if (sb.size() > 0) void'(sb.pop_front());
            m_valid = 1'b0;
         end
         ev = 1'b0;
         if (can && g >= 0) begin
            e = satModel(in_data[g*IW +: IW], g);
            sb.push_back(e);
            m_valid = 1'b1;
            m_ptr   = g;
            ev      = (e.sat != 2'b00);
         end
         if (clr_stats) begin
            m_flags = ev ? (1 << g) : 0;
            m_count = ev ? 1 : 0;
         end else if (ev) begin
            m_flags = m_flags | (1 << g);
            if (m_count < (1 << CNTW) - 1) m_count++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle's worth of inputs and step the clock.
   task automatic applyStimulus(input logic [N-1:0] v, input logic [N*IW-1:0] d,
                                input logic rdy, input logic clr);
      in_valid  = v;
      in_data   = d;
      out_ready = rdy;
      clr_stats = clr;
      runCycle();
   endtask

   function automatic logic [N*IW-1:0] oneChan(input int ch, input logic [IW-1:0] val);
      logic [N*IW-1:0] d;
      d = '0;
      d[ch*IW +: IW] = val;
      return d;
   endfunction

   function automatic logic [N*IW-1:0] allChan(input int base);
      logic [N*IW-1:0] d;
      d = '0;
      for (int k = 0; k < N; k++) d[k*IW +: IW] = IW'(k * 256 + base);
      return d;
   endfunction

   initial begin
      tbl[0] = '{chan: 1, data: 22'h008000, exp_data: 16'h7FFF, exp_sat: 2'b10};
      tbl[1] = '{chan: 1, data: 22'h200000, exp_data: 16'h8000, exp_sat: 2'b01};
      tbl[2] = '{chan: 1, data: 22'h3FFFFF, exp_data: 16'hFFFF, exp_sat: 2'b00};
      tbl[3] = '{chan: 1, data: 22'h3F8000, exp_data: 16'h8000, exp_sat: 2'b00};

      rst_n     = 1'b0;
      in_valid  = '0;
      in_data   = '0;
      out_ready = 1'b1;
      clr_stats = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_out_data", 32'(out_data), 32'd0);
      checkOutput("rst_out_chan", 32'(out_chan), 32'd0);
      checkOutput("rst_out_sat", 32'(out_sat), 32'd0);
      checkOutput("rst_sat_flags", 32'(sat_flags), 32'd0);
      checkOutput("rst_sat_count", 32'(sat_count), 32'd0);

      $display("[TB] exact sample on channel 0");
      applyStimulus(4'b0001, oneChan(0, 22'h007FFF), 1'b1, 1'b0);
      checkOutput("first_valid", 32'(out_valid), 32'd1);
      checkOutput("first_data", 32'(out_data), 32'h7FFF);
      checkOutput("first_chan", 32'(out_chan), 32'd0);
      checkOutput("first_sat", 32'(out_sat), 32'd0);
      checkOutput("first_count", 32'(sat_count), 32'd0);
      applyStimulus('0, '0, 1'b1, 1'b0);

      $display("[TB] boundary table on channel 1");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(N'(1 << tbl[i].chan), oneChan(tbl[i].chan, tbl[i].data), 1'b1, 1'b0);
         checkOutput($sformatf("tbl%0d_data", i), 32'(out_data), 32'(tbl[i].exp_data));
         checkOutput($sformatf("tbl%0d_sat", i), 32'(out_sat), 32'(tbl[i].exp_sat));
         checkOutput($sformatf("tbl%0d_chan", i), 32'(out_chan), 32'(tbl[i].chan));
      end
      applyStimulus('0, '0, 1'b1, 1'b0);
      checkOutput("tbl_flags", 32'(sat_flags), 32'h2);
      checkOutput("tbl_count", 32'(sat_count), 32'd2);

      $display("[TB] round-robin fairness");
      applyStimulus(4'b1000, oneChan(3, 22'h000033), 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(4'b1111, allChan(i), 1'b1, 1'b0);
         checkOutput($sformatf("rr%0d_chan", i), 32'(out_chan), 32'(i % N));
      end

      $display("[TB] backpressure");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(4'b1111, allChan(16 + i), 1'b0, 1'b0);
         checkOutput($sformatf("bp%0d_chan", i), 32'(out_chan), 32'd3);
         checkOutput($sformatf("bp%0d_data", i), 32'(out_data), 32'(3 * 256 + 7));
      end
      applyStimulus(4'b1111, allChan(32), 1'b1, 1'b0);
      checkOutput("bp_resume_chan", 32'(out_chan), 32'd0);
      applyStimulus('0, '0, 1'b1, 1'b0);

      $display("[TB] clear coinciding with an event");
      applyStimulus(4'b0100, oneChan(2, 22'h100000), 1'b1, 1'b1);
      checkOutput("clr_flags", 32'(sat_flags), 32'h4);
      checkOutput("clr_count", 32'(sat_count), 32'd1);
      checkOutput("clr_sat", 32'(out_sat), 32'h2);

      $display("[TB] counter saturation");
      for (int i = 0; i < 20; i++) begin
         applyStimulus(4'b0001, oneChan(0, 22'h200000), 1'b1, 1'b0);
      end
      applyStimulus('0, '0, 1'b1, 1'b0);
      checkOutput("cnt_hold", 32'(sat_count), 32'd15);
      checkOutput("cnt_flags", 32'(sat_flags), 32'h5);

      $display("[TB] reset during held sample");
      applyStimulus(4'b0010, oneChan(1, 22'h000123), 1'b1, 1'b0);
      rst_n = 1'b0;
      applyStimulus('0, '0, 1'b0, 1'b0);
      rst_n = 1'b1;
      checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
      checkOutput("mid_rst_flags", 32'(sat_flags), 32'd0);
      checkOutput("mid_rst_count", 32'(sat_count), 32'd0);
      applyStimulus(4'b1111, allChan(48), 1'b1, 1'b0);
      checkOutput("post_rst_chan", 32'(out_chan), 32'd0);
      applyStimulus('0, '0, 1'b1, 1'b0);
      applyStimulus('0, '0, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sat_narrow_scheduler.md
Name: sat_narrow_scheduler

Overview:
- Shares one registered saturating-narrowing stage (IW-bit signed to OW-bit signed) among N requester channels.
- Uses round-robin arbitration with valid/ready handshakes on every input and on the single output.
- Tags each output sample with its source channel and its saturation direction.
- Keeps per-channel sticky overflow flags and a global saturation event counter for controller diagnostics.

Parameters:
- N, 4, number of requester channels (2..16)
- IW, 22, input sample width, signed two's complement; IW > OW required
- OW, 16, output sample width, signed two's complement
- CW, 2, channel index width; must satisfy 2^CW >= N
- CNTW, 16, width of the saturation event counter

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  N  per-channel request valid
- in_data  in  N*IW  channel k occupies bits [k*IW +: IW]
- in_ready  out  N  one-hot (or zero) accept strobe to the granted channel
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accept
- out_data  out  OW  saturated sample
- out_chan  out  CW  source channel of out_data
- out_sat  out  2  bit1 = clipped to MAX, bit0 = clipped to MIN, 00 = exact
- clr_stats  in  1  clears sat_flags and sat_count
- sat_flags  out  N  sticky per-channel "saturated since last clear"
- sat_count  out  CNTW  total saturation events, stops at all-ones

Behaviour:
- One clock; reset is synchronous and active-low (clk, rst_n). These values are fixed.
- Reset values, with rst_n low at a clock edge:
  - out_valid=0, out_data=0, out_chan=0, out_sat=00
  - sat_flags=0, sat_count=0
  - round-robin pointer = N-1, so channel 0 has first priority
- Reset mid-transfer discards the held output sample; no flag or count update occurs that cycle.
- Stage free: can_load = !out_valid || out_ready.
- Grant (combinational):
  - Search channels starting at ptr+1 and wrapping modulo N; the first channel with in_valid=1 is granted.
  - in_ready[g] = can_load && in_valid[g]; all other in_ready bits are 0.
  - in_ready is 0 whenever no channel is valid or can_load=0.
- Transfer happens on a cycle with in_valid[g] && in_ready[g]. At the next edge:
  - out_valid=1, out_chan=g, ptr=g
  - out_data and out_sat are updated per the saturation rules below.
- Latency: exactly 1 cycle from accept to out_valid.
- Throughput: 1 sample per cycle while out_ready stays high.
- Output held: if out_valid && !out_ready, then out_data, out_chan and out_sat hold stable, no input is accepted, and ptr holds.
- If out_ready=1 with no transfer that cycle, out_valid clears to 0.
- Saturation, with MAX = 2^(OW-1)-1 and MIN = -2^(OW-1):
  - Let top = in[IW-2:OW-1].
  - Positive overflow: sign=0 and top nonzero → out_data=MAX, out_sat=10.
  - Negative overflow: sign=1 and top not all ones → out_data=MIN, out_sat=01.
  - Otherwise out_data = in[OW-1:0], out_sat=00.
- Statistics, updated at the accept edge (not the output edge):
  - A saturation event is any accepted sample with out_sat != 00.
  - On an event, sat_flags[g] is set and sat_count increments, holding at 2^CNTW-1 (no wrap).
- clr_stats=1 clears all flags and the counter. If an event occurs in the same cycle:
  - set wins for that channel's flag;
  - sat_count loads 1.
- Fairness: with all N channels continuously valid and out_ready=1, grants cycle 0,1,…,N-1,0,…; no channel waits more than N-1 accepts.

Test Plan:
- Reset, then channel 0 only, in_data=0x007FFF, out_ready=1 → next cycle out_valid=1, out_data=0x7FFF, out_chan=0, out_sat=00; sat_count=0.
- Boundary values on channel 1 (IW=22, OW=16):
  - 0x008000 → 0x7FFF, out_sat=10
  - 0x200000 → 0x8000, out_sat=01
  - 0x3FFFFF → 0xFFFF, out_sat=00
  - 0x3F8000 → 0x8000, out_sat=00
  - Afterwards sat_flags=0010, sat_count=2.
- All 4 channels valid, out_ready=1 for 8 cycles → out_chan sequence 0,1,2,3,0,1,2,3; each in_ready one-hot; one grant per cycle.
- Backpressure: out_ready=0 for 3 cycles while all channels valid → out_data and out_chan stable, in_ready=0000. Release → stream resumes with the next channel after the held one.
- clr_stats asserted in the same cycle channel 2 accepts 0x100000 → sat_flags=0100, sat_count=1. Counter preloaded near full with CNTW=4: 20 saturating samples → sat_count holds at 15.
- rst_n low for one cycle while out_valid=1 and out_ready=0 → next cycle out_valid=0, flags/count cleared; next grant goes to channel 0.
